// File: rtl/raster_tagger.sv
// Tags a sof/eol-framed ready/valid pixel stream with col/row, checks line and frame geometry,
// and optionally blanks s_ready_o after each line. Macro RASTER_TAGGER_STATS_EN adds frame/error counters.
module raster_tagger #(
    parameter int DATA_WIDTH   = 16,
    parameter int IMAGE_WIDTH  = 64,
    parameter int IMAGE_HEIGHT = 64,
    parameter int LINE_GAP     = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_sof_i,
    input  logic                  s_eol_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [15:0]           col_o,
    output logic [15:0]           row_o,
    output logic                  valid_o,
    output logic                  frame_done_o,
    output logic                  line_err_o,
    output logic                  sof_err_o,
    output logic [15:0]           frame_count_o,
    output logic [15:0]           err_count_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_GAP, ST_RESYNC} state_t;

    localparam logic [15:0] COL_LAST = 16'(IMAGE_WIDTH - 1);
    localparam logic [15:0] ROW_LAST = 16'(IMAGE_HEIGHT - 1);
    localparam logic [7:0]  GAP_LOAD = 8'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);
    localparam bit          HAS_GAP  = (LINE_GAP > 0);

    state_t                state_q, state_d;
    logic [15:0]           col_q, col_d;
    logic [15:0]           row_q, row_d;
    logic [7:0]            gap_q, gap_d;
    logic                  gap_eof_q, gap_eof_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [15:0]           out_col_q, out_col_d;
    logic [15:0]           out_row_q, out_row_d;
    logic                  valid_q, valid_d;
    logic                  fd_q, fd_d;
    logic                  le_q, le_d;
    logic                  se_q, se_d;

    logic                  accept;
    logic                  emit;
    logic [15:0]           eff_col;
    logic [15:0]           eff_row;

    // Ready is held low through reset as well as during line blanking.
    assign s_ready_o = !rst_i && (state_q != ST_GAP);
    assign accept    = s_valid_i && s_ready_o;

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        gap_d     = gap_q;
        gap_eof_d = gap_eof_q;
        data_d    = data_q;
        out_col_d = out_col_q;
        out_row_d = out_row_q;
        valid_d   = 1'b0;
        fd_d      = 1'b0;
        le_d      = 1'b0;
        se_d      = 1'b0;
        emit      = 1'b0;
        eff_col   = col_q;
        eff_row   = row_q;

        // A sof beat always restarts at (0,0); its eol is then judged at col 0.
        if (accept) begin
            if (s_sof_i) begin
                emit    = 1'b1;
                eff_col = 16'd0;
                eff_row = 16'd0;
                se_d    = (state_q == ST_ACTIVE);
            end else if (state_q == ST_ACTIVE) begin
                emit = 1'b1;
            end
        end

        if (emit) begin
            valid_d   = 1'b1;
            data_d    = s_data_i;
            out_col_d = eff_col;
            out_row_d = eff_row;
            if (s_eol_i != (eff_col == COL_LAST)) begin
                le_d    = 1'b1;
                col_d   = 16'd0;
                row_d   = 16'd0;
                state_d = ST_RESYNC;
            end else if (!s_eol_i) begin
                col_d   = eff_col + 16'd1;
                row_d   = eff_row;
                state_d = ST_ACTIVE;
            end else begin
                col_d = 16'd0;
                gap_d = GAP_LOAD;
                if (eff_row == ROW_LAST) begin
                    fd_d      = 1'b1;
                    row_d     = 16'd0;
                    gap_eof_d = 1'b1;
                    state_d   = HAS_GAP ? ST_GAP : ST_IDLE;
                end else begin
                    row_d     = eff_row + 16'd1;
                    gap_eof_d = 1'b0;
                    state_d   = HAS_GAP ? ST_GAP : ST_ACTIVE;
                end
            end
        end else if (state_q == ST_GAP) begin
            if (gap_q == 8'd0) begin
                state_d = gap_eof_q ? ST_IDLE : ST_ACTIVE;
            end else begin
                gap_d = gap_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            gap_q     <= '0;
            gap_eof_q <= 1'b0;
            data_q    <= '0;
            out_col_q <= '0;
            out_row_q <= '0;
            valid_q   <= 1'b0;
            fd_q      <= 1'b0;
            le_q      <= 1'b0;
            se_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            gap_q     <= gap_d;
            gap_eof_q <= gap_eof_d;
            data_q    <= data_d;
            out_col_q <= out_col_d;
            out_row_q <= out_row_d;
            valid_q   <= valid_d;
            fd_q      <= fd_d;
            le_q      <= le_d;
            se_q      <= se_d;
        end
    end

    assign data_o       = data_q;
    assign col_o        = out_col_q;
    assign row_o        = out_row_q;
    assign valid_o      = valid_q;
    assign frame_done_o = fd_q;
    assign line_err_o   = le_q;
    assign sof_err_o    = se_q;

`ifdef RASTER_TAGGER_STATS_EN
    logic [15:0] frame_count_q;
    logic [15:0] err_count_q;

    // Counters follow the registered pulses, so they update one cycle after them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_count_q <= '0;
            err_count_q   <= '0;
        end else begin
            if (fd_q) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
            if ((le_q || se_q) && (err_count_q != 16'hFFFF)) begin
                err_count_q <= err_count_q + 16'd1;
            end
        end
    end

    assign frame_count_o = frame_count_q;
    assign err_count_o   = err_count_q;
`else
    assign frame_count_o = 16'd0;
    assign err_count_o   = 16'd0;
`endif

endmodule
